i2s_master: RTL and testbench

Clock-master I2S port. Generates `bclk` and `lrclk` from `sys_clk`, serialises a stereo sample pair on `dout`, and deserialises `din` into a stereo pair each frame. It is the controller end of the link that the slave-mode transceiver serves. It drives codecs or slave ports that need a bit clock and word select, and its framing matches the slave's: one-bit I2S delay, MSB first, zero-padded slots.

---
 rtl/i2s_master_pkg.sv | 13 +
 rtl/i2s_bclk_gen.sv | 50 +++++
 rtl/i2s_master.sv | 129 ++++++++++++
 tb/tb_i2s_master.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/i2s_master_pkg.sv
// Shared helpers for the I2S master slice.
// Latency: n/a (compile-time only).
// Backpressure: n/a.
//
// Contents: cnt_width() - register width needed to count 0..n-1, never less than 1 bit,
// so a divide-by-1 divider still gets a legal (unused-range) counter.
package i2s_master_pkg;

  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/i2s_bclk_gen.sv
// Bit-clock generator: divides sys_clk by 2*clk_div and flags the bclk edges.
// Latency: rise/fall strobes are combinational in the cycle before bclk changes.
// Backpressure: none; i_enable low freezes the divider and bclk and suppresses strobes.
//
// Ports:
//   i_sys_clk, i_reset_n   clock, async active-low reset
//   i_enable               run; low holds all state
//   o_bclk                 registered bit clock
//   o_rise / o_fall        one-cycle strobes; bclk goes 0->1 / 1->0 at the next edge
module i2s_bclk_gen #(
  parameter int clk_div = 4
) (
  input  logic i_sys_clk,
  input  logic i_reset_n,
  input  logic i_enable,
  output logic o_bclk,
  output logic o_rise,
  output logic o_fall
);
  import i2s_master_pkg::*;

  localparam int DW = cnt_width(clk_div);
  localparam logic [DW-1:0] DIV_LAST = DW'(clk_div - 1);

  logic [DW-1:0] r_div_ctr;
  logic          r_bclk;
  logic          w_tc;

  // Terminal count only counts while running, so strobes are gated by enable too.
  assign w_tc = i_enable && (r_div_ctr == DIV_LAST);

  always_ff @(posedge i_sys_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_div_ctr <= '0;
      r_bclk    <= 1'b0;
    end else if (i_enable) begin
      if (w_tc) begin
        r_div_ctr <= '0;
        r_bclk    <= ~r_bclk;
      end else begin
        r_div_ctr <= r_div_ctr + DW'(1);
      end
    end
  end

  assign o_bclk = r_bclk;
  assign o_rise = w_tc & ~r_bclk;
  assign o_fall = w_tc & r_bclk;

endmodule

// File: rtl/i2s_master.sv
// Clock-master I2S port: generates bclk/lrclk, serialises tx pair on dout, deserialises din.
// Latency: pair latched at frame start (tx_ready) returns on rx_* at the end of the same frame in loopback.
// Backpressure: none; enable low freezes the link, tx_l/tx_r are sampled only on the tx_ready cycle.
//
// Ports:
//   sys_clk, reset_n        clock, async active-low reset
//   enable                  run; low holds all state, no pulses
//   din                     serial data in, sampled at bclk rise events
//   tx_l, tx_r              samples to send, latched when tx_ready pulses
//   bclk, lrclk, dout       registered link outputs (lrclk 0 = left)
//   tx_ready                one-cycle pulse: tx pair latched
//   rx_l, rx_r, rx_valid    last received pair and its one-cycle update pulse
module i2s_master #(
  parameter int sample_size = 16,
  parameter int slot_bits   = 32,
  parameter int clk_div     = 4
) (
  input  logic                   sys_clk,
  input  logic                   reset_n,
  input  logic                   enable,
  input  logic                   din,
  input  logic [sample_size-1:0] tx_l,
  input  logic [sample_size-1:0] tx_r,
  output logic                   bclk,
  output logic                   lrclk,
  output logic                   dout,
  output logic                   tx_ready,
  output logic [sample_size-1:0] rx_l,
  output logic [sample_size-1:0] rx_r,
  output logic                   rx_valid
);
  import i2s_master_pkg::*;

  localparam int SS = sample_size;
  localparam int BW = cnt_width(2 * slot_bits);
  localparam logic [BW-1:0] B_LAST = BW'(2 * slot_bits - 1);
  localparam logic [BW-1:0] SLOT   = BW'(slot_bits);
  localparam logic [BW-1:0] SS_B   = BW'(sample_size);
  localparam logic [SS-1:0] ONE    = SS'(1);

  logic          w_bclk, w_rise, w_fall;

  logic [BW-1:0] r_b;
  logic          r_lrclk, r_dout, r_primed, r_tx_ready, r_rx_valid;
  logic [SS-1:0] r_tx_l, r_tx_r, r_sr_l, r_sr_r, r_rx_l, r_rx_r;

  logic [BW-1:0] w_b_next, w_np, w_p, w_idx;
  logic          w_next_right, w_cur_right, w_np_in, w_p_in, w_tx_bit;
  logic [SS-1:0] w_tx_ch, w_sr_l_next, w_sr_r_next;

  i2s_bclk_gen #(.clk_div(clk_div)) u_bclk_gen (
    .i_sys_clk (sys_clk),
    .i_reset_n (reset_n),
    .i_enable  (enable),
    .o_bclk    (w_bclk),
    .o_rise    (w_rise),
    .o_fall    (w_fall)
  );

  // Fall side: everything is computed from the bit index we are about to enter.
  assign w_b_next     = (r_b == B_LAST) ? '0 : r_b + BW'(1);
  assign w_next_right = (w_b_next >= SLOT);
  assign w_np         = w_next_right ? (w_b_next - SLOT) : w_b_next;
  assign w_np_in      = (w_np != '0) && (w_np <= SS_B);
  // Position 1 carries the MSB (one-bit I2S delay); out-of-range idx is masked by w_np_in.
  assign w_idx        = SS_B - w_np;
  assign w_tx_ch      = w_next_right ? r_tx_r : r_tx_l;
  assign w_tx_bit     = w_np_in && (|(w_tx_ch & (ONE << w_idx)));

  // Rise side: din belongs to the bit index currently on the wire.
  assign w_cur_right  = (r_b >= SLOT);
  assign w_p          = w_cur_right ? (r_b - SLOT) : r_b;
  assign w_p_in       = (w_p != '0) && (w_p <= SS_B);

  // Next shift-register values are formed combinationally so the end-of-frame copy
  // sees the final right bit when the sample fills the slot up to its last position.
  assign w_sr_l_next  = (w_rise && w_p_in && !w_cur_right) ? {r_sr_l[SS-2:0], din} : r_sr_l;
  assign w_sr_r_next  = (w_rise && w_p_in &&  w_cur_right) ? {r_sr_r[SS-2:0], din} : r_sr_r;

  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_b        <= B_LAST;
      r_lrclk    <= 1'b1;
      r_dout     <= 1'b0;
      r_primed   <= 1'b0;
      r_tx_ready <= 1'b0;
      r_rx_valid <= 1'b0;
      r_tx_l     <= '0;
      r_tx_r     <= '0;
      r_sr_l     <= '0;
      r_sr_r     <= '0;
      r_rx_l     <= '0;
      r_rx_r     <= '0;
    end else begin
      r_tx_ready <= 1'b0;
      r_rx_valid <= 1'b0;
      r_sr_l     <= w_sr_l_next;
      r_sr_r     <= w_sr_r_next;

      if (w_fall) begin
        r_b     <= w_b_next;
        r_lrclk <= w_next_right;
        r_dout  <= w_tx_bit;
        if (w_b_next == '0) begin
          r_tx_l     <= tx_l;
          r_tx_r     <= tx_r;
          r_tx_ready <= 1'b1;
          r_primed   <= 1'b1;
        end
      end

      // Only frames that started after a real frame boundary are reported.
      if (w_rise && (r_b == B_LAST) && r_primed) begin
        r_rx_l     <= w_sr_l_next;
        r_rx_r     <= w_sr_r_next;
        r_rx_valid <= 1'b1;
      end
    end
  end

  assign bclk     = w_bclk;
  assign lrclk    = r_lrclk;
  assign dout     = r_dout;
  assign tx_ready = r_tx_ready;
  assign rx_l     = r_rx_l;
  assign rx_r     = r_rx_r;
  assign rx_valid = r_rx_valid;

endmodule

// File: tb/tb_i2s_master.sv
module tb_i2s_master;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Default configuration, dout looped back to din.
  logic        rst_n, en, din, bclk, lrclk, dout, tx_ready, rx_valid;
  logic [15:0] tx_l, tx_r, rx_l, rx_r;
  assign din = dout;

  i2s_master #(.sample_size(16), .slot_bits(32), .clk_div(4)) dut (
    .sys_clk(clk), .reset_n(rst_n), .enable(en), .din(din),
    .tx_l(tx_l), .tx_r(tx_r), .bclk(bclk), .lrclk(lrclk), .dout(dout),
    .tx_ready(tx_ready), .rx_l(rx_l), .rx_r(rx_r), .rx_valid(rx_valid)
  );

  // Tight configuration: divide-by-1, sample fills slot up to its last position.
  logic        rst2_n, en2, din2, bclk2, lrclk2, dout2, tx2_ready, rx2_valid;
  logic [15:0] tx2_l, tx2_r, rx2_l, rx2_r;
  assign din2 = dout2;

  i2s_master #(.sample_size(16), .slot_bits(17), .clk_div(1)) dut2 (
    .sys_clk(clk), .reset_n(rst2_n), .enable(en2), .din(din2),
    .tx_l(tx2_l), .tx_r(tx2_r), .bclk(bclk2), .lrclk(lrclk2), .dout(dout2),
    .tx_ready(tx2_ready), .rx_l(rx2_l), .rx_r(rx2_r), .rx_valid(rx2_valid)
  );

  int          n_vec  = 0;
  int          n_miss = 0;
  int          cyc    = 0;
  logic [63:0] last_od;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Reference for one frame: dout at bit index b (0..63) of a 2x32-slot frame.
  function automatic logic ref_bit(input logic [15:0] l, input logic [15:0] r, input int b);
    logic [15:0] ch, tmp;
    int          p;
    ch = (b < 32) ? l : r;
    p  = b % 32;
    if (p < 1 || p > 16) return 1'b0;
    tmp = ch >> (16 - p);
    return tmp[0];
  endfunction

  // Entered on the sample where tx_ready is high. Observes one whole frame on the
  // default DUT, checks serial stream, word select, bclk period and loopback result,
  // then loads nl/nr and waits for the next frame start.
  task automatic frame1(input string tag, input logic [15:0] nl, input logic [15:0] nr,
                        input int stall_at);
    logic [15:0] el, er, cl, cr;
    logic [63:0] od, ol, ed;
    int          rises, rxv_cnt, rxv_at, txr_cnt, bad_per, hold_err, guard, last, w;
    logic        pb, skip, sb, sl, sd;
    el = tx_l; er = tx_r;
    // Junk on the inputs mid-frame must not reach the wire.
    tx_l = 16'($urandom); tx_r = 16'($urandom);
    od = '0; ol = '0; ed = '0; cl = '0; cr = '0;
    rises = 0; rxv_cnt = 0; rxv_at = -1; txr_cnt = 0; bad_per = 0; hold_err = 0; guard = 0;
    pb = bclk; skip = 1'b1; last = cyc;
    while (rises < 64 && guard < 1200) begin
      tick(); guard++;
      if (tx_ready) txr_cnt++;
      if (bclk && !pb) begin
        rises++;
        od = {od[62:0], dout};
        ol = {ol[62:0], lrclk};
        if (!skip && (cyc - last) != 8) bad_per++;
        skip = 1'b0; last = cyc;
        if (rises == stall_at) begin
          sb = bclk; sl = lrclk; sd = dout;
          en = 1'b0;
          for (int i = 0; i < 20; i++) begin
            tick();
            if (bclk !== sb || lrclk !== sl || dout !== sd || tx_ready || rx_valid) hold_err++;
          end
          en = 1'b1;
          skip = 1'b1;
        end
      end
      if (rx_valid) begin rxv_cnt++; rxv_at = rises; cl = rx_l; cr = rx_r; end
      pb = bclk;
    end
    for (int b = 0; b < 64; b++) ed = {ed[62:0], ref_bit(el, er, b)};
    chk({tag, " rise_count"},   64'(rises), 64'd64);
    chk({tag, " dout_stream"},  od, ed);
    chk({tag, " lrclk_stream"}, ol, 64'h0000_0000_FFFF_FFFF);
    chk({tag, " rx_valid_cnt"}, 64'(rxv_cnt), 64'd1);
    chk({tag, " rx_valid_pos"}, 64'(rxv_at), 64'd64);
    chk({tag, " rx_l"},         64'(cl), 64'(el));
    chk({tag, " rx_r"},         64'(cr), 64'(er));
    chk({tag, " tx_ready_mid"}, 64'(txr_cnt), 64'd0);
    chk({tag, " bclk_period"},  64'(bad_per), 64'd0);
    if (stall_at > 0) chk({tag, " hold"}, 64'(hold_err), 64'd0);
    last_od = od;
    tx_l = nl; tx_r = nr;
    w = 0;
    while (!tx_ready && w < 40) begin tick(); w++; end
    chk({tag, " tx_ready_gap"}, 64'(w), 64'd4);
  endtask

  initial begin
    int          n, rxv, tog_err;
    logic        pb;
    logic [15:0] el, er;

    rst_n = 1'b0; en = 1'b0; tx_l = 16'hA5C3; tx_r = 16'h0F0F;
    rst2_n = 1'b0; en2 = 1'b0; tx2_l = 16'hFFFF; tx2_r = 16'h0000;
    repeat (3) tick();

    chk("rst bclk",     64'(bclk),     64'd0);
    chk("rst lrclk",    64'(lrclk),    64'd1);
    chk("rst dout",     64'(dout),     64'd0);
    chk("rst tx_ready", 64'(tx_ready), 64'd0);
    chk("rst rx_valid", 64'(rx_valid), 64'd0);
    chk("rst rx_l",     64'(rx_l),     64'd0);
    chk("rst rx_r",     64'(rx_r),     64'd0);

    // Start: first frame boundary 2*clk_div cycles after enable, no rx_valid before it.
    rst_n = 1'b1;
    tick();
    en = 1'b1;
    n = 0; rxv = 0;
    while (!tx_ready && n < 100) begin tick(); n++; if (rx_valid) rxv++; end
    chk("first tx_ready latency", 64'(n), 64'd8);
    chk("rx_valid before primed", 64'(rxv), 64'd0);

    frame1("loop", 16'h8001, 16'($urandom), 0);
    frame1("fmt", 16'($urandom), 16'($urandom), 0);
    chk("fmt left slot 8001", 64'(last_od[63:32]), 64'h4000_8000);
    for (int i = 0; i < 2; i++) frame1("rand", 16'($urandom), 16'($urandom), 0);
    frame1("stall", 16'($urandom), 16'($urandom), 10);
    frame1("pre_rst", 16'($urandom), 16'($urandom), 0);

    // Asynchronous reset mid-frame, checked before the next clock edge.
    repeat (100) tick();
    rst_n = 1'b0;
    #1;
    chk("midrst bclk",     64'(bclk),     64'd0);
    chk("midrst lrclk",    64'(lrclk),    64'd1);
    chk("midrst dout",     64'(dout),     64'd0);
    chk("midrst rx_l",     64'(rx_l),     64'd0);
    chk("midrst rx_r",     64'(rx_r),     64'd0);
    chk("midrst tx_ready", 64'(tx_ready), 64'd0);
    chk("midrst rx_valid", 64'(rx_valid), 64'd0);
    repeat (3) tick();
    rst_n = 1'b1;
    n = 0; rxv = 0;
    while (!tx_ready && n < 100) begin tick(); n++; if (rx_valid) rxv++; end
    chk("post-reset tx_ready latency", 64'(n), 64'd8);
    chk("post-reset early rx_valid",   64'(rxv), 64'd0);
    frame1("post_rst", 16'($urandom), 16'($urandom), 0);

    // Divide-by-1, 17-bit slots.
    rst2_n = 1'b1;
    tick();
    en2 = 1'b1;
    pb = bclk2; n = 0; tog_err = 0;
    while (!tx2_ready && n < 10) begin
      tick(); n++;
      if (bclk2 === pb) tog_err++;
      pb = bclk2;
    end
    chk("div1 first tx_ready", 64'(n), 64'd2);
    for (int f = 0; f < 2; f++) begin
      el = tx2_l; er = tx2_r;
      tx2_l = 16'($urandom); tx2_r = 16'($urandom);
      n = 0;
      while (!rx2_valid && n < 100) begin
        tick(); n++;
        if (bclk2 === pb) tog_err++;
        pb = bclk2;
      end
      chk("div1 rx_valid latency", 64'(n), 64'd67);
      chk("div1 rx_l", 64'(rx2_l), 64'(el));
      chk("div1 rx_r", 64'(rx2_r), 64'(er));
      tick();
      if (bclk2 === pb) tog_err++;
      pb = bclk2;
      chk("div1 next tx_ready", 64'(tx2_ready), 64'd1);
    end
    chk("div1 bclk toggles every cycle", 64'(tog_err), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
